// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM/UART port between the instruction
// fetch unit (IF, always 32-bit reads) and the load/store buffer (LSB,
// byte/half/word loads and stores). Multi-byte accesses are serialised one
// byte per cycle, little-endian, starting at the latched base address.
//
// Ports:
//   clk, rst (async, active-low), rdy (0 = freeze), rob_clear (flush)
//   mem_din / mem_dout / mem_a / mem_wr : byte RAM port (read data one cycle late)
//   io_buffer_full                      : UART back-pressure for writes >= IO_BASE
//   if_req / if_addr / if_done / if_data
//   lsb_req / lsb_we / lsb_size / lsb_unsigned / lsb_addr / lsb_wdata
//   lsb_done / lsb_rdata
//   busy                                : controller not idle
module mem_arbiter #(
  parameter logic [31:0] IO_BASE   = 32'h0003_0000,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_size,
  input  logic        lsb_unsigned,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        lsb_q, lsb_d;            // current owner is the LSB
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] base_q, base_d;
  logic [31:0] data_q, data_d;          // store data, or bytes captured so far
  logic [2:0]  cnt_q, cnt_d;            // next byte to issue / write
  logic        cap_q, cap_d;            // a read byte is due on mem_din this cycle
  logic        last_lsb_q, last_lsb_d;  // LSB won the last completed grant

  logic [2:0]  n_bytes;
  logic [31:0] cur_addr;
  logic [7:0]  wr_byte;
  logic [1:0]  cap_off;
  logic [31:0] load_ext;
  logic        grant_lsb;

  assign n_bytes   = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
  assign cur_addr  = base_q + {29'd0, cnt_q};
  assign wr_byte   = data_q[{cnt_q[1:0], 3'b000} +: 8];
  // Byte being captured was issued one step earlier; wraps 4 -> 3 correctly.
  assign cap_off   = cnt_q[1:0] - 2'd1;
  assign grant_lsb = lsb_req && (!if_req || !last_lsb_q);
  assign busy      = (state_q != IDLE);

  always_comb begin
    load_ext = data_q;
    case (size_q)
      2'd0: load_ext = uns_q ? {24'd0, data_q[7:0]} : {{24{data_q[7]}}, data_q[7:0]};
      2'd1: load_ext = uns_q ? {16'd0, data_q[15:0]} : {{16{data_q[15]}}, data_q[15:0]};
      default: load_ext = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lsb_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      base_q     <= 32'd0;
      data_q     <= 32'd0;
      cnt_q      <= 3'd0;
      cap_q      <= 1'b0;
      last_lsb_q <= !LSB_FIRST;
    end else begin
      state_q    <= state_d;
      lsb_q      <= lsb_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      base_q     <= base_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      last_lsb_q <= last_lsb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lsb_d      = lsb_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    base_d     = base_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    last_lsb_d = last_lsb_q;
    mem_a      = 32'd0;
    mem_dout   = 8'd0;
    mem_wr     = 1'b0;
    if_done    = 1'b0;
    if_data    = 32'd0;
    lsb_done   = 1'b0;
    lsb_rdata  = 32'd0;

    case (state_q)
      IDLE: begin
        if (rdy && !rob_clear && (if_req || lsb_req)) begin
          lsb_d   = grant_lsb;
          we_d    = grant_lsb & lsb_we;
          size_d  = grant_lsb ? lsb_size : 2'd2;   // fetch is always a word
          uns_d   = grant_lsb & lsb_unsigned;
          base_d  = grant_lsb ? lsb_addr : if_addr;
          data_d  = (grant_lsb & lsb_we) ? lsb_wdata : 32'd0;
          cnt_d   = 3'd0;
          cap_d   = 1'b0;
          state_d = (grant_lsb & lsb_we) ? WRITE : READ;
        end
      end

      READ: begin
        if (!rdy) begin
          // The byte arriving now is dropped; step back so it is reissued.
          if (cap_q) begin
            cnt_d = cnt_q - 3'd1;
            cap_d = 1'b0;
          end
        end else if (rob_clear) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          cap_d   = 1'b0;
        end else begin
          if (cap_q) data_d[{cap_off, 3'b000} +: 8] = mem_din;
          if (cnt_q < n_bytes) begin
            mem_a = cur_addr;
            cnt_d = cnt_q + 3'd1;
            cap_d = 1'b1;
          end else begin
            cnt_d   = 3'd0;
            cap_d   = 1'b0;
            state_d = DONE;
          end
        end
      end

      WRITE: begin
        // Stores are already committed, so rob_clear has no effect here.
        if (rdy) begin
          mem_a    = cur_addr;
          mem_dout = wr_byte;
          if (!(cur_addr >= IO_BASE && io_buffer_full)) begin
            mem_wr = 1'b1;
            if (cnt_q == n_bytes - 3'd1) begin
              cnt_d   = 3'd0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end

      DONE: begin
        if (rdy) begin
          state_d = IDLE;
          if (!(rob_clear && !we_q)) begin
            last_lsb_d = lsb_q;
            if (lsb_q) begin
              lsb_done  = 1'b1;
              lsb_rdata = load_ext;
            end else begin
              if_done = 1'b1;
              if_data = data_q;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rob_clear = 1'b0;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req = 1'b0;
  logic        lsb_we = 1'b0;
  logic [1:0]  lsb_size = 2'd0;
  logic        lsb_unsigned = 1'b0;
  logic [31:0] lsb_addr = 32'd0;
  logic [31:0] lsb_wdata = 32'd0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.IO_BASE(32'h0003_0000), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size),
    .lsb_unsigned(lsb_unsigned), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata), .busy(busy)
  );

  // RAM model: read byte appears one cycle after its address; writes logged.
  logic [7:0]  ram [0:255];
  logic [31:0] a_hold = 32'd0;
  logic [39:0] wlog [0:63];
  int          wcnt = 0;

  always @(negedge clk) begin
    a_hold <= mem_a;
    if (mem_wr) begin
      wlog[wcnt[5:0]] <= {mem_a, mem_dout};
      wcnt <= wcnt + 1;
    end
  end

  always @(posedge clk) mem_din <= ram[a_hold[7:0]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        lsb;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rbytes;   // RAM bytes at addr..addr+3 (loads)
    logic [31:0] exp_data; // expected load / fetch result
    int          exp_lat;  // cycle of the done pulse; 0 = no pulse expected
    logic [15:0] rdy_lo;   // per-cycle: rdy low
    logic [15:0] rob;      // per-cycle: rob_clear high (requests dropped too)
    logic [15:0] full;     // per-cycle: io_buffer_full high
    int          idle_chk; // cycle where busy must be 0, -1 = none
  } vec_t;

  vec_t vecs [0:21];

  task automatic run_vec(input int idx, input vec_t v);
    int port, lat, n, w0, exp_port;
    logic [31:0] data;
    logic [39:0] e;
    w0 = wcnt;
    if (!v.we) for (int k = 0; k < 4; k++) ram[8'(v.addr + 32'(k))] = v.rbytes[8*k +: 8];
    port = 0; lat = 0; data = 32'd0;
    rdy = !v.rdy_lo[0]; rob_clear = v.rob[0]; io_buffer_full = v.full[0];
    if (v.lsb) begin
      lsb_we = v.we; lsb_size = v.size; lsb_unsigned = v.uns;
      lsb_addr = v.addr; lsb_wdata = v.wdata; lsb_req = 1'b1;
    end else begin
      if_addr = v.addr; if_req = 1'b1;
    end
    for (int c = 1; c <= 40 && port == 0; c++) begin
      @(posedge clk); #1;
      if (c < 16) begin
        rdy = !v.rdy_lo[c[3:0]]; rob_clear = v.rob[c[3:0]]; io_buffer_full = v.full[c[3:0]];
      end else begin
        rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
      end
      if (rob_clear) begin if_req = 1'b0; lsb_req = 1'b0; end
      #1;
      if (c == v.idle_chk) check($sformatf("v%0d idle_after_clear", idx), {31'd0, busy}, 32'd0);
      if (if_done && lsb_done) port = 3;
      else if (if_done) begin port = 1; data = if_data; end
      else if (lsb_done) begin port = 2; data = lsb_rdata; end
      if (port != 0) begin lat = c; if_req = 1'b0; lsb_req = 1'b0; end
    end
    if_req = 1'b0; lsb_req = 1'b0; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;

    exp_port = (v.exp_lat == 0) ? 0 : (v.lsb ? 2 : 1);
    check($sformatf("v%0d done_port", idx), 32'(port), 32'(exp_port));
    if (exp_port != 0) begin
      check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
      if (!v.we) check($sformatf("v%0d rdata", idx), data, v.exp_data);
      @(posedge clk); #2;
      check($sformatf("v%0d pulse_width", idx), {30'd0, if_done, lsb_done}, 32'd0);
      check($sformatf("v%0d idle_after_done", idx), {31'd0, busy}, 32'd0);
    end
    n = !v.we ? 0 : (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    check($sformatf("v%0d write_count", idx), 32'(wcnt - w0), 32'(n));
    for (int k = 0; k < n && k < wcnt - w0; k++) begin
      e = wlog[6'(w0 + k)];
      check($sformatf("v%0d wr_addr%0d", idx, k), e[39:8], v.addr + 32'(k));
      check($sformatf("v%0d wr_byte%0d", idx, k), {24'd0, e[7:0]}, {24'd0, v.wdata[8*k +: 8]});
    end
    $display("vec %0d: port=%0d lat=%0d data=%h writes=%0d", idx, port, lat, data, wcnt - w0);
  endtask

  // Both requesters held high; records which port completes, oldest in bits [1:0].
  task automatic tie(input int n, output logic [5:0] seq);
    int got;
    got = 0; seq = 6'd0;
    lsb_we = 1'b0; lsb_size = 2'd0; lsb_unsigned = 1'b0; lsb_addr = 32'h20;
    if_addr = 32'h100; lsb_req = 1'b1; if_req = 1'b1;
    for (int c = 1; c <= 60 && got < n; c++) begin
      @(posedge clk); #2;
      if (if_done || lsb_done) begin
        seq[2*got +: 2] = {lsb_done, if_done};
        got++;
      end
    end
    lsb_req = 1'b0; if_req = 1'b0;
    @(posedge clk); #2;
    $display("tie: %0d grants, order=%b", got, seq);
  endtask

  initial begin
    logic [5:0] seq;
    int dones;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;

    //           lsb   we    size  uns   addr           wdata          rbytes         exp            lat rdy_lo   rob      full     idle
    vecs[0]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0513, 32'h0000_0513, 6, 16'h0,    16'h0,    16'h0,    -1};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0080, 32'hFFFF_FF80, 3, 16'h0,    16'h0,    16'h0,    -1};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080, 32'h0000_0080, 3, 16'h0,    16'h0,    16'h0,    -1};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0041, 32'h0,         32'h0000_F234, 32'hFFFF_F234, 4, 16'h0,    16'h0,    16'h0,    -1};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0041, 32'h0,         32'h0000_F234, 32'h0000_F234, 4, 16'h0,    16'h0,    16'h0,    -1};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0052, 32'h0,         32'h1234_5678, 32'h1234_5678, 6, 16'h0,    16'h0,    16'h0,    -1};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0000_7CAB, 32'h0000_7CAB, 4, 16'h0,    16'h0,    16'h0,    -1};
    vecs[7]  = '{1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_0060, 32'h0,         32'h8403_0201, 32'h8403_0201, 6, 16'h0,    16'h0,    16'h0,    -1};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0033, 32'h0,         32'h0000_007F, 32'h0000_007F, 3, 16'h0,    16'h0,    16'h0,    -1};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0070, 32'h1122_3344, 32'h0,         32'h0,         2, 16'h0,    16'h0,    16'h0,    -1};
    vecs[10] = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0081, 32'hAABB_CCDD, 32'h0,         32'h0,         3, 16'h0,    16'h0,    16'h0,    -1};
    vecs[11] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0090, 32'hDEAD_BEEF, 32'h0,         32'h0,         5, 16'h0,    16'h0,    16'h0,    -1};
    vecs[12] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0102_0304, 32'h0,         32'h0,         5, 16'h0,    16'h0,    16'h0,    -1};
    vecs[13] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0003_0000, 32'hDEAD_BEEF, 32'h0,         32'h0,         8, 16'h0,    16'h0,    16'h001C, -1};
    vecs[14] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0002_FFFF, 32'h0000_00A5, 32'h0,         32'h0,         2, 16'h0,    16'h0,    16'hFFFF, -1};
    vecs[15] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0003_0000, 32'h0000_005A, 32'h0,         32'h0,         4, 16'h0,    16'h0,    16'h0006, -1};
    vecs[16] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0513, 32'h0,         0, 16'h0,    16'h0008, 16'h0,     4};
    vecs[17] = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_00A0, 32'h0000_5566, 32'h0,         32'h0,         3, 16'h0,    16'h000E, 16'h0,    -1};
    vecs[18] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0080, 32'h0,         0, 16'h0,    16'h0008, 16'h0,    -1};
    vecs[19] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_00B0, 32'h0,         32'h0403_0201, 32'h0403_0201, 8, 16'h0008, 16'h0,    16'h0,    -1};
    vecs[20] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0080, 32'hFFFF_FF80, 4, 16'h0008, 16'h0,    16'h0,    -1};
    vecs[21] = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_00C0, 32'h0000_9988, 32'h0,         32'h0,         4, 16'h0002, 16'h0,    16'h0,    -1};

    // Reset state
    #12;
    check("reset mem_a", mem_a, 32'd0);
    check("reset mem_dout_wr", {23'd0, mem_dout, mem_wr}, 32'd0);
    check("reset dones_busy", {29'd0, if_done, lsb_done, busy}, 32'd0);
    check("reset if_data", if_data, 32'd0);
    check("reset lsb_rdata", lsb_rdata, 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #2;
    $display("reset: outputs sampled");

    // First ties after reset: LSB, IF, LSB
    tie(3, seq);
    check("tie order", {26'd0, seq}, 32'h0000_0026);

    // Reset in the middle of a word load: no done pulse afterwards
    lsb_we = 1'b0; lsb_size = 2'd2; lsb_unsigned = 1'b0; lsb_addr = 32'hD0; lsb_req = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("busy before reset", {31'd0, busy}, 32'd1);
    check("mem_a before reset", mem_a, 32'h0000_00D1);
    rst = 1'b0; #1;
    check("busy in reset", {31'd0, busy}, 32'd0);
    check("mem_a in reset", mem_a, 32'd0);
    lsb_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk); #2;
      if (if_done || lsb_done) dones++;
    end
    check("no done after mid reset", 32'(dones), 32'd0);
    $display("midreset: %0d done pulses after abort", dones);

    // Last-grant restored by reset: LSB wins the tie again
    tie(1, seq);
    check("tie after reset", {26'd0, seq}, 32'h0000_0002);

    for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0003_0000, meaning: addresses >= IO_BASE are UART-mapped.
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning: the port that wins the first tie after reset is LSB (1) or IF (0).
REQ-003 SHALL have the following ports, with clock and reset first:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global enable; 0 = freeze
- rob_clear  in  1  pipeline flush
- mem_din  in  8  RAM read byte, valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART full
- if_req  in  1  fetch request, level
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle completion pulse
- if_data  out  32  fetched word, valid with if_done
- lsb_req  in  1  LSB request, level
- lsb_we  in  1  1 = store
- lsb_size  in  2  0 byte, 1 half, 2 word; 3 treated as word
- lsb_unsigned  in  1  zero-extend load
- lsb_addr  in  32  data address
- lsb_wdata  in  32  store data
- lsb_done  out  1  one-cycle completion pulse
- lsb_rdata  out  32  extended load data, valid with lsb_done
- busy  out  1  state != IDLE

Function
REQ-004 SHALL implement the states IDLE, READ, WRITE, DONE.
REQ-005 In IDLE, the block SHALL sample the requests; if exactly one is asserted, that port is granted; if both are asserted, the port not granted last wins; the base address, size and data are latched; the next state is READ, or WRITE if (lsb_we and LSB is granted).
REQ-006 The byte count N SHALL be 4 for IF and 1/2/4 for LSB per lsb_size; byte k SHALL be at base+k (little-endian).
REQ-007 READ SHALL drive mem_a=base+k, mem_wr=0 in issue cycles k=0..N-1, capture mem_din into byte k on the following cycle, and enter DONE after the last capture; request-to-done latency SHALL be N+2 cycles.
REQ-008 WRITE SHALL drive mem_a=base+k, mem_dout=byte k, mem_wr=1 for k=0..N-1, then enter DONE; latency SHALL be N+1 cycles when unstalled.
REQ-009 If a WRITE byte address >= IO_BASE and io_buffer_full=1, the block SHALL hold that byte with mem_wr=0 and k unchanged until io_buffer_full=0.
REQ-010 In DONE, the block SHALL pulse exactly one of if_done/lsb_done with its data, ignore the requests, and go to IDLE; requesters drop req in the done cycle.
REQ-011 lsb_rdata SHALL be:
- byte/half: sign-extended from bit 7/15, or zero-extended if lsb_unsigned=1
- word: the raw value
REQ-012 Outside IDLE-to-grant and active cycles, mem_a=0, mem_dout=0, mem_wr=0.
REQ-013 When rob_clear=1 during READ, IDLE or DONE (for reads), the block SHALL abort to IDLE next cycle with no done pulse, not update last-grant, and ignore same-cycle requests.
REQ-014 When rob_clear=1 during WRITE, the block SHALL be ignored by the write (committed store): the write completes and lsb_done pulses.
REQ-015 When rdy=0, the block SHALL hold all state, force mem_wr=0 and suppress done pulses; a read capture due in a frozen cycle SHALL be discarded and that byte reissued after rdy returns.
REQ-016 Byte addresses SHALL wrap modulo 2^32; no alignment is required.

Reset
REQ-017 rst=0 SHALL asynchronously force IDLE, all outputs 0, byte counter 0, captured data 0, and last-grant such that the first tie follows LSB_FIRST.
REQ-018 Reset release SHALL take effect on the next clk edge; reset asserted mid-operation SHALL abandon the transfer with no done pulse.

Verification
REQ-019 IF only, if_addr=0x100 with RAM bytes 13,05,00,00 -> mem_a 0x100..0x103, if_done at cycle 6, if_data=0x00000513.
REQ-020 LSB lb at 0x20 with byte 0x80, lsb_unsigned=0 -> lsb_rdata=0xFFFFFF80 at cycle 3; with lsb_unsigned=1 -> 0x00000080.
REQ-021 if_req and lsb_req both high from reset, held through two grants -> LSB served first, then IF; then both high again -> LSB granted.
REQ-022 sw 0xDEADBEEF to 0x30000 with io_buffer_full high for 3 cycles at k=1 -> mem_dout sequence EF,BE,AD,DE, mem_wr low for the 3 stall cycles, lsb_done at cycle 8.
REQ-023 rob_clear in cycle 3 of an IF read -> no if_done, IDLE at cycle 4; rob_clear during an sh -> both bytes written, lsb_done pulses.
